// File: rtl/defs.sv
// Shared definitions for the instruction fetch path: datapath width,
// default reset PC and the fetch controller state encoding.
package defs;

  localparam int unsigned BIN_DIG = 32;
  localparam logic [BIN_DIG-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues one word-indexed request at a time,
// hands the returned instruction to decode and services writeback redirects.
module fetch_controller
  import defs::*;
#(
  parameter int unsigned        BIN_DIG  = defs::BIN_DIG,
  parameter logic [BIN_DIG-1:0] RESET_PC = BIN_DIG'(defs::RESET_PC),
  parameter logic [BIN_DIG-1:0] PC_STEP  = BIN_DIG'(1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [BIN_DIG-1:0] redirect_pc,
  output logic               imem_req,
  output logic [BIN_DIG-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [BIN_DIG-1:0] imem_rdata,
  output logic               inst_valid,
  output logic [BIN_DIG-1:0] inst,
  output logic [BIN_DIG-1:0] inst_pc,
  input  logic               decode_ready
);

  fetch_state_t       state;
  logic [BIN_DIG-1:0] pc;
  logic [BIN_DIG-1:0] pc_pending;

  // The request address is the live PC; it only moves when a request completes.
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pc_pending <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) pc <= redirect_pc;
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (redirect_valid) begin
            if (imem_ack) begin
              pc <= redirect_pc;
            end else begin
              // The memory still owns the old address; finish it, then discard.
              pc_pending <= redirect_pc;
              state      <= DROP;
            end
          end else if (imem_ack) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= HOLD;
          end
        end

        HOLD: begin
          if (redirect_valid || decode_ready) begin
            pc         <= redirect_valid ? redirect_pc : pc + PC_STEP;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end
        end

        DROP: begin
          if (redirect_valid) pc_pending <= redirect_pc;
          if (imem_ack) begin
            pc    <= redirect_valid ? redirect_pc : pc_pending;
            state <= FETCH;
          end
        end

        default: begin
          state      <= IDLE;
          inst_valid <= 1'b0;
          imem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table for the fetch, stall,
// redirect, wrap and reset sequences, then randomized traffic against a model.
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        decode_ready;

  fetch_controller #(
    .BIN_DIG (32),
    .RESET_PC(32'h0),
    .PC_STEP (32'h1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .decode_ready  (decode_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          rv;
    logic [31:0] rpc;
    bit          ack;
    logic [31:0] rdata;
    bit          rdy;
    bit          chk;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Row builders: request cycle, holding cycle, idle cycle after reset.
  task automatic rq(input logic [31:0] a, input bit ack, input logic [31:0] rd,
                    input bit rv = 0, input logic [31:0] rpc = 0, input bit rs = 0);
    tbl.push_back('{rs, rv, rpc, ack, rd, 1'b1, 1'b1, 1'b1, a, 1'b0, 32'h0, 32'h0});
  endtask

  task automatic hd(input logic [31:0] i, input logic [31:0] p, input bit rdy,
                    input bit rv = 0, input logic [31:0] rpc = 0);
    tbl.push_back('{1'b0, rv, rpc, 1'b0, 32'h0, rdy, 1'b1, 1'b0, 32'h0, 1'b1, i, p});
  endtask

  task automatic id(input bit rv = 0, input logic [31:0] rpc = 0);
    tbl.push_back('{1'b0, rv, rpc, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Reference model state for the random phase.
  bit          armed, prev_rst, prev_req, prev_ack;
  logic [31:0] prev_addr;
  bit          pv;
  logic [31:0] pinst, ppc, exp_pc, rpc;
  bit          stale, mbusy, xfer, cur_ack;
  int unsigned mwait, mdelay, transfers;

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; decode_ready = 1'b0;

    tbl.push_back('{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    id();
    rq(0, 1, 'h100);  hd('h100, 0, 1);
    rq(1, 1, 'h101);  hd('h101, 1, 1);
    rq(2, 1, 'h102);  repeat (4) hd('h102, 2, 0);  hd('h102, 2, 1);
    rq(3, 1, 'h103);  hd('h103, 3, 1);
    rq(4, 1, 'h104);  hd('h104, 4, 1);
    repeat (3) rq(5, 0, 0);  rq(5, 1, 'h105);  hd('h105, 5, 1);
    rq(6, 1, 'h106);  hd('h106, 6, 1);
    rq(7, 0, 0, 1, 'h40);  rq(7, 0, 0);  rq(7, 1, 'h107);
    rq('h40, 1, 'h140);  hd('h140, 'h40, 1);
    rq('h41, 0, 0, 1, 'h40);  rq('h41, 0, 0, 1, 'h80);  rq('h41, 1, 'h141);
    rq('h80, 1, 'h180);  hd('h180, 'h80, 1, 1, 'h20);
    rq('h20, 1, 'h120);  hd('h120, 'h20, 1);
    rq('h21, 1, 'h121, 1, 'hFFFF_FFFF);
    rq('hFFFF_FFFF, 1, 'h55);  hd('h55, 'hFFFF_FFFF, 1);
    rq(0, 0, 0, 1, 'h9);  rq(0, 0, 0, 1, 'h33);  rq(0, 0, 0, 0, 0, 1);
    id();  rq(0, 1, 'h100);  hd('h100, 0, 1);
    rq(1, 0, 0, 0, 0, 1);
    id(1, 'h10);  rq('h10, 1, 'h110);  hd('h110, 'h10, 1);
    rq('h11, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("row%0d_req", i), imem_req, tbl[i].e_req);
        if (tbl[i].e_req) chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
        chk($sformatf("row%0d_valid", i), inst_valid, tbl[i].e_valid);
        if (!tbl[i].e_req) begin
          chk($sformatf("row%0d_inst", i), inst, tbl[i].e_inst);
          chk($sformatf("row%0d_inst_pc", i), inst_pc, tbl[i].e_pc);
        end
      end
      rst = tbl[i].rst; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
      imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata; decode_ready = tbl[i].rdy;
    end

    armed = 0; prev_rst = 0; prev_req = 0; prev_ack = 0; prev_addr = '0;
    pv = 0; pinst = '0; ppc = '0; exp_pc = '0; stale = 0; mbusy = 0;
    mwait = 0; mdelay = 0; transfers = 0;

    for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst            = (cyc == 0) || ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
        default: rpc = 32'($urandom_range(0, 255));
      endcase
      redirect_pc  = rpc;
      decode_ready = ($urandom_range(0, 2) != 0);
      imem_ack     = 1'b0;
      imem_rdata   = $urandom;
      if (imem_req) begin
        if (!mbusy) begin
          mbusy = 1; mwait = 0; mdelay = $urandom_range(0, 3);
        end
        if (mwait == mdelay) begin
          imem_ack = 1'b1; imem_rdata = memfn(imem_addr);
        end
      end

      if (armed) begin
        chk("rnd_valid", inst_valid, pv);
        if (pv) begin
          chk("rnd_inst", inst, pinst);
          chk("rnd_inst_pc", inst_pc, ppc);
        end
        if (prev_rst) chk("rnd_req_after_rst", imem_req, 0);
        else          chk("rnd_not_stalled", imem_req | inst_valid, 1);
        if (!prev_rst && prev_req && !prev_ack) begin
          chk("rnd_req_held", imem_req, 1);
          chk("rnd_addr_held", imem_addr, prev_addr);
        end
        if (imem_req && (!prev_req || prev_ack)) chk("rnd_fetch_addr", imem_addr, exp_pc);
        chk("rnd_req_and_valid", imem_req & inst_valid, 0);
      end

      if (rst) begin
        pv = 0; exp_pc = 32'h0; stale = 0; mbusy = 0;
      end else begin
        xfer    = pv && decode_ready;
        cur_ack = imem_req && imem_ack && !stale;
        if (xfer) begin
          exp_pc = ppc + 32'h1;
          transfers++;
        end
        if (redirect_valid) exp_pc = redirect_pc;
        if (redirect_valid) pv = 0;
        else if (pv && !decode_ready) pv = 1;
        else if (cur_ack) begin
          pv = 1; pinst = imem_rdata; ppc = imem_addr;
        end else pv = 0;
        if (imem_req && imem_ack) begin
          stale = 0; mbusy = 0;
        end else if (imem_req) begin
          if (redirect_valid) stale = 1;
          mwait++;
        end
      end
      prev_rst = rst; prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      armed = 1;
    end

    chk("rnd_progress", 32'(transfers > 200), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
